// File: rtl/light_pkg.sv
// Shared types and default timing for the multi-zone lighting controller.
package light_pkg;

    typedef enum logic [1:0] {
        AUTO_IDLE  = 2'd0,
        AUTO_ON    = 2'd1,
        MANUAL_OFF = 2'd2,
        MANUAL_ON  = 2'd3
    } zone_state_t;

    typedef enum logic [1:0] {
        EVT_NONE  = 2'd0,
        EVT_SHORT = 2'd1,
        EVT_LONG  = 2'd2
    } press_evt_t;

    localparam int DEF_SYNC_STAGES      = 2;
    localparam int DEF_DEBOUNCE_CYCLES  = 300;
    localparam int DEF_MODE_HOLD_CYCLES = 5000;
    localparam int DEF_AUTO_HOLD_CYCLES = 30000;

    // Lamp is driven in both "on" states.
    function automatic logic lamp_of(zone_state_t s);
        return (s == AUTO_ON) || (s == MANUAL_ON);
    endfunction

    // Manual mode covers both MANUAL_* states.
    function automatic logic manual_of(zone_state_t s);
        return (s == MANUAL_OFF) || (s == MANUAL_ON);
    endfunction

endpackage

// File: rtl/light_zone.sv
// One lighting zone: input synchronisers, button debounce, short/long press
// classifier, mode/lamp FSM and automatic-mode hold timer.
module light_zone
    import light_pkg::*;
#(
    parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int MODE_HOLD_CYCLES = DEF_MODE_HOLD_CYCLES,
    parameter int AUTO_HOLD_CYCLES = DEF_AUTO_HOLD_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,       // raw, asynchronous
    input  logic pir_i,       // raw, asynchronous
    input  logic daylight_i,  // already synchronised
    input  logic all_off_i,   // synchronous single-cycle
    output logic lamp_o,
    output logic mode_o
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW  = $clog2(MODE_HOLD_CYCLES + 1);
    localparam int TW  = $clog2(AUTO_HOLD_CYCLES + 1);

    logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
    logic [SYNC_STAGES-1:0] pir_sync_q, pir_sync_d;
    logic                   db_q, db_d, db_prev_q;
    logic [DBW-1:0]         db_cnt_q, db_cnt_d;
    logic [PW-1:0]          press_cnt_q, press_cnt_d;
    press_evt_t             evt_q, evt_d;
    zone_state_t            state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   lamp_q, mode_q;

    logic btn_s, pir_s;
    assign btn_s = btn_sync_q[SYNC_STAGES-1];
    assign pir_s = pir_sync_q[SYNC_STAGES-1];

    // Synchroniser shift and debounce: level follows input only after a full stable run.
    always_comb begin
        btn_sync_d = {btn_sync_q[SYNC_STAGES-2:0], btn_i};
        pir_sync_d = {pir_sync_q[SYNC_STAGES-2:0], pir_i};
        db_d       = db_q;
        db_cnt_d   = '0;
        if (btn_s != db_q) begin
            if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) db_d = btn_s;
            else                                       db_cnt_d = db_cnt_q + DBW'(1);
        end
    end

    // Press classifier: LONG once the hold count is hit, SHORT on release if not consumed.
    // A saturated counter marks the press as consumed until the button is released.
    always_comb begin
        press_cnt_d = press_cnt_q;
        evt_d       = EVT_NONE;
        if (db_q) begin
            if (press_cnt_q != PW'(MODE_HOLD_CYCLES)) press_cnt_d = press_cnt_q + PW'(1);
            if (press_cnt_q == PW'(MODE_HOLD_CYCLES - 1)) evt_d = EVT_LONG;
        end else begin
            press_cnt_d = '0;
            if (db_prev_q && (press_cnt_q != PW'(MODE_HOLD_CYCLES))) evt_d = EVT_SHORT;
        end
    end

    // Zone FSM and hold timer; ALL_OFF wins over any same-cycle event.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (all_off_i) begin
            if (manual_of(state_q)) begin
                state_d = MANUAL_OFF;
            end else begin
                state_d = AUTO_IDLE;
                timer_d = '0;
            end
        end else begin
            unique case (state_q)
                AUTO_IDLE: begin
                    if (evt_q == EVT_LONG) begin
                        state_d = MANUAL_OFF;
                    end else if (pir_s && !daylight_i) begin
                        state_d = AUTO_ON;
                        timer_d = TW'(AUTO_HOLD_CYCLES);
                    end
                end
                AUTO_ON: begin
                    if (evt_q == EVT_LONG) begin
                        state_d = MANUAL_OFF;
                        timer_d = '0;
                    end else if (pir_s) begin
                        timer_d = TW'(AUTO_HOLD_CYCLES);
                    end else if (timer_q <= TW'(1)) begin
                        state_d = AUTO_IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                MANUAL_OFF: begin
                    if (evt_q == EVT_SHORT)     state_d = MANUAL_ON;
                    else if (evt_q == EVT_LONG) state_d = AUTO_IDLE;
                end
                MANUAL_ON: begin
                    if (evt_q == EVT_SHORT) begin
                        state_d = MANUAL_OFF;
                    end else if (evt_q == EVT_LONG) begin
                        state_d = AUTO_IDLE;
                        timer_d = '0;
                    end
                end
                default: state_d = AUTO_IDLE;
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_sync_q  <= '0;
            pir_sync_q  <= '0;
            db_q        <= 1'b0;
            db_prev_q   <= 1'b0;
            db_cnt_q    <= '0;
            press_cnt_q <= '0;
            evt_q       <= EVT_NONE;
            state_q     <= AUTO_IDLE;
            timer_q     <= '0;
            lamp_q      <= 1'b0;
            mode_q      <= 1'b0;
        end else begin
            btn_sync_q  <= btn_sync_d;
            pir_sync_q  <= pir_sync_d;
            db_q        <= db_d;
            db_prev_q   <= db_q;
            db_cnt_q    <= db_cnt_d;
            press_cnt_q <= press_cnt_d;
            evt_q       <= evt_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            lamp_q      <= lamp_of(state_d);
            mode_q      <= manual_of(state_d);
        end
    end

    assign lamp_o = lamp_q;
    assign mode_o = mode_q;

endmodule

// File: rtl/multi_zone_light_ctrl.sv
// Multi-zone lighting controller: shared DAYLIGHT synchroniser, ALL_OFF fan-out,
// and one independent light_zone per lamp.
module multi_zone_light_ctrl
    import light_pkg::*;
#(
    parameter int N_ZONES          = 2,
    parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int MODE_HOLD_CYCLES = DEF_MODE_HOLD_CYCLES,
    parameter int AUTO_HOLD_CYCLES = DEF_AUTO_HOLD_CYCLES
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [N_ZONES-1:0] PUSH_BUTTON,
    input  logic [N_ZONES-1:0] INFRAVERMELHO,
    input  logic               DAYLIGHT,
    input  logic               ALL_OFF,
    output logic [N_ZONES-1:0] LAMPADA,
    output logic [N_ZONES-1:0] MODO
);

    logic [SYNC_STAGES-1:0] dl_sync_q;

    // DAYLIGHT synchroniser shared by all zones.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) dl_sync_q <= '0;
        else        dl_sync_q <= {dl_sync_q[SYNC_STAGES-2:0], DAYLIGHT};
    end

    for (genvar gi = 0; gi < N_ZONES; gi++) begin : g_zone
        light_zone #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .MODE_HOLD_CYCLES(MODE_HOLD_CYCLES),
            .AUTO_HOLD_CYCLES(AUTO_HOLD_CYCLES)
        ) u_zone (
            .clk_i     (CLK),
            .rst_ni    (RESET),
            .btn_i     (PUSH_BUTTON[gi]),
            .pir_i     (INFRAVERMELHO[gi]),
            .daylight_i(dl_sync_q[SYNC_STAGES-1]),
            .all_off_i (ALL_OFF),
            .lamp_o    (LAMPADA[gi]),
            .mode_o    (MODO[gi])
        );
    end

endmodule

// File: tb/tb_multi_zone_light_ctrl.sv
// Scoreboard bench for multi_zone_light_ctrl with short timing constants.
module tb_multi_zone_light_ctrl;

    logic       CLK;
    logic       RESET;
    logic [1:0] PUSH_BUTTON;
    logic [1:0] INFRAVERMELHO;
    logic       DAYLIGHT;
    logic       ALL_OFF;
    logic [1:0] LAMPADA;
    logic [1:0] MODO;

    multi_zone_light_ctrl #(
        .N_ZONES(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .MODE_HOLD_CYCLES(20), .AUTO_HOLD_CYCLES(10)
    ) dut (
        .CLK(CLK), .RESET(RESET), .PUSH_BUTTON(PUSH_BUTTON),
        .INFRAVERMELHO(INFRAVERMELHO), .DAYLIGHT(DAYLIGHT), .ALL_OFF(ALL_OFF),
        .LAMPADA(LAMPADA), .MODO(MODO)
    );

    typedef struct {
        int cyc;
        int lamp;
        int modo;
    } exp_t;

    exp_t  sb[$];
    exp_t  e;
    int    cyc = 0;
    int    n_run = 0;
    int    n_fail = 0;
    int    b;
    string cur_tag = "init";

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Compare DUT outputs against the head of the scoreboard when its cycle comes up.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            if (sb[0].cyc < cyc) begin
                e = sb.pop_front();
                chk({cur_tag, "_late"}, e.cyc, cyc);
            end else if (sb[0].cyc == cyc) begin
                e = sb.pop_front();
                chk({cur_tag, "_lamp"}, 32'(LAMPADA), e.lamp);
                chk({cur_tag, "_modo"}, 32'(MODO), e.modo);
            end
        end
    end

    task automatic push(input int from, input int to, input int lamp, input int modo);
        for (int c = from; c <= to; c++) sb.push_back('{c, lamp, modo});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_pir(input logic [1:0] mask);
        INFRAVERMELHO = mask;
        tick(1);
        INFRAVERMELHO = 2'b00;
    endtask

    task automatic press(input int z, input int len);
        PUSH_BUTTON[z] = 1'b1;
        tick(len);
        PUSH_BUTTON[z] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() > 0; i++) @(negedge CLK);
        if (sb.size() > 0) begin
            chk({cur_tag, "_timeout"}, sb.size(), 0);
            sb.delete();
        end
    endtask

    // Short press from MANUAL_OFF: lamp on 16 cycles after press start.
    task automatic short_on(input int modo);
        b = cyc;
        push(b + 1, b + 15, 0, modo);
        push(b + 16, b + 25, 1, modo);
        press(0, 8);
        drain();
    endtask

    // Long press: mode flips somewhere in press-start+25..+26, settled by +27.
    task automatic long_press(input int lamp0, input int modo0, input int lamp1, input int modo1);
        b = cyc;
        push(b + 1, b + 24, lamp0, modo0);
        push(b + 27, b + 45, lamp1, modo1);
        press(0, 30);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        RESET = 1'b0; PUSH_BUTTON = 2'b00; INFRAVERMELHO = 2'b00;
        DAYLIGHT = 1'b0; ALL_OFF = 1'b0;
        tick(2);
        chk("rst_lamp", 32'(LAMPADA), 0);
        chk("rst_modo", 32'(MODO), 0);
        RESET = 1'b1;
        tick(3);

        // Reset mid-operation with lamp 0 lit.
        cur_tag = "s1_pre";
        b = cyc;
        push(b + 1, b + 2, 0, 0);
        push(b + 3, b + 6, 1, 0);
        pulse_pir(2'b01);
        tick(5);
        #2 RESET = 1'b0;
        #1 chk("rst_async_lamp", 32'(LAMPADA), 0);
        chk("rst_async_modo", 32'(MODO), 0);
        tick(3);
        RESET = 1'b1;
        tick(2);

        // Single motion pulse: lamp on for exactly 10 cycles, 3 cycles after the pulse.
        cur_tag = "s1_pulse";
        b = cyc;
        push(b + 1, b + 2, 0, 0);
        push(b + 3, b + 12, 1, 0);
        push(b + 13, b + 14, 0, 0);
        pulse_pir(2'b01);
        drain();

        // Daylight inhibits turn-on.
        cur_tag = "s2_day";
        DAYLIGHT = 1'b1;
        tick(4);
        b = cyc;
        push(b + 1, b + 15, 0, 0);
        pulse_pir(2'b01);
        drain();
        DAYLIGHT = 1'b0;
        tick(4);

        // Retrigger: three pulses 6 cycles apart keep the lamp on continuously.
        cur_tag = "s2_retrig";
        b = cyc;
        push(b + 1, b + 2, 0, 0);
        push(b + 3, b + 24, 1, 0);
        push(b + 25, b + 26, 0, 0);
        pulse_pir(2'b01);
        tick(5);
        pulse_pir(2'b01);
        tick(5);
        pulse_pir(2'b01);
        drain();

        // Both zones in the same cycle.
        cur_tag = "s2_both";
        b = cyc;
        push(b + 1, b + 2, 0, 0);
        push(b + 3, b + 12, 3, 0);
        push(b + 13, b + 14, 0, 0);
        pulse_pir(2'b11);
        drain();

        // Glitch shorter than the debounce window produces nothing.
        cur_tag = "s3_glitch";
        b = cyc;
        push(b + 1, b + 20, 0, 0);
        press(0, 3);
        drain();

        // Long press enters manual; release must not toggle the lamp.
        cur_tag = "s3_long";
        long_press(0, 0, 0, 1);

        // Manual toggle on, then off; zone 1 stays idle.
        cur_tag = "s4_on";
        short_on(1);
        cur_tag = "s4_off";
        b = cyc;
        push(b + 1, b + 15, 1, 1);
        push(b + 16, b + 25, 0, 1);
        press(0, 8);
        drain();

        // Long press from MANUAL_ON returns to auto with lamp off, motion works again.
        cur_tag = "s5_on";
        short_on(1);
        cur_tag = "s5_long";
        long_press(1, 1, 0, 0);
        cur_tag = "s5_pir";
        b = cyc;
        push(b + 1, b + 2, 0, 0);
        push(b + 3, b + 12, 1, 0);
        push(b + 13, b + 14, 0, 0);
        pulse_pir(2'b01);
        drain();

        // Zone 0 manual on, zone 1 auto on, ALL_OFF collides with zone 0 SHORT.
        cur_tag = "s6_long";
        long_press(0, 0, 0, 1);
        cur_tag = "s6_on";
        short_on(1);
        cur_tag = "s6_alloff";
        b = cyc;
        push(b + 1, b + 12, 1, 1);
        push(b + 13, b + 15, 3, 1);
        push(b + 16, b + 25, 0, 1);
        PUSH_BUTTON[0] = 1'b1;
        tick(8);
        PUSH_BUTTON[0] = 1'b0;
        tick(2);
        pulse_pir(2'b10);
        tick(4);
        ALL_OFF = 1'b1;
        tick(1);
        ALL_OFF = 1'b0;
        drain();

        // From MANUAL_OFF a colliding SHORT and a colliding motion sample are both dropped.
        cur_tag = "s6_discard";
        b = cyc;
        push(b + 1, b + 25, 0, 1);
        PUSH_BUTTON[0] = 1'b1;
        tick(8);
        PUSH_BUTTON[0] = 1'b0;
        tick(5);
        INFRAVERMELHO = 2'b10;
        tick(1);
        INFRAVERMELHO = 2'b00;
        tick(1);
        ALL_OFF = 1'b1;
        tick(1);
        ALL_OFF = 1'b0;
        drain();

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
